// File: rtl/core_general_pkg.sv
// Shared core constants: datapath width, ROM address width, reset PC and the NOP encoding.
package core_general;
    localparam int          XLEN     = 32;
    localparam int          AWIDTH   = 12;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
endpackage

// File: rtl/rom.sv
// Instruction ROM with a registered read port; contents are preloaded into mem and never written.
module rom
    import core_general::*;
#(
    parameter int XLEN   = core_general::XLEN,
    parameter int AWIDTH = core_general::AWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AWIDTH-1:0] addr,
    output logic [XLEN-1:0]   qout
);

    logic [XLEN-1:0] mem [0:(2**AWIDTH)-1];

    // Only the output register is reset; mem keeps its image across reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            qout <= '0;
        end else begin
            qout <= mem[addr];
        end
    end

endmodule

// File: rtl/top_fetch.sv
// Fetch stage: PC register, ROM word addressing and the instruction hold register.
// Build option FETCH_JUMP_ALIGN_EN clears bits [1:0] of jump targets before loading the PC.
module top_fetch
    import core_general::*;
#(
    parameter int              XLEN     = core_general::XLEN,
    parameter int              AWIDTH   = core_general::AWIDTH,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(core_general::RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              phase_fetch,
    input  logic              phase_writeback,
    input  logic              jump_state_wf,
    input  logic [XLEN-1:0]   regdata_for_pc,
    input  logic [XLEN-1:0]   inst_data,
    output logic [AWIDTH-1:0] inst_addr,
    output logic [XLEN-1:0]   curr_pc_fd,
    output logic [XLEN-1:0]   next_pc_fd,
    output logic [XLEN-1:0]   inst,
    output logic              stall_fetch
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_hold;
    logic            r_dec_vld_p1;
    logic [XLEN-1:0] w_pc_seq;
    logic [XLEN-1:0] w_jump_tgt;

    assign w_pc_seq = r_pc + XLEN'(4);

`ifdef FETCH_JUMP_ALIGN_EN
    assign w_jump_tgt = {regdata_for_pc[XLEN-1:2], 2'b00};
`else
    assign w_jump_tgt = regdata_for_pc;
`endif

    // Jump request is only honoured in the writeback cycle.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_pc <= RESET_PC;
        end else if (phase_writeback) begin
            r_pc <= jump_state_wf ? w_jump_tgt : w_pc_seq;
        end
    end

    // ---- p1: decode cycle, ROM data valid ----
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_dec_vld_p1 <= 1'b0;
            r_hold       <= XLEN'(core_general::NOP);
        end else begin
            r_dec_vld_p1 <= phase_fetch;
            if (r_dec_vld_p1) begin
                r_hold <= inst_data;
            end
        end
    end

    assign inst_addr   = r_pc[AWIDTH+1:2];
    assign curr_pc_fd  = r_pc;
    assign next_pc_fd  = w_pc_seq;
    assign inst        = r_dec_vld_p1 ? inst_data : r_hold;
    assign stall_fetch = phase_fetch & ~rst_n;

endmodule

// File: tb/tb_top_fetch.sv
// Bench for top_fetch beside rom: phase-sequenced instructions with a scoreboard of expected fetches.
module tb_top_fetch;

    localparam int XLEN   = 32;
    localparam int AWIDTH = 12;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_I  = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              phase_fetch;
    logic              phase_writeback;
    logic              jump_state_wf;
    logic [XLEN-1:0]   regdata_for_pc;
    logic [XLEN-1:0]   inst_data;
    logic [AWIDTH-1:0] inst_addr;
    logic [XLEN-1:0]   curr_pc_fd;
    logic [XLEN-1:0]   next_pc_fd;
    logic [XLEN-1:0]   inst;
    logic              stall_fetch;

    always #5 clk = ~clk;

    top_fetch #(.XLEN(XLEN), .AWIDTH(AWIDTH), .RESET_PC(RST_PC)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .phase_fetch     (phase_fetch),
        .phase_writeback (phase_writeback),
        .jump_state_wf   (jump_state_wf),
        .regdata_for_pc  (regdata_for_pc),
        .inst_data       (inst_data),
        .inst_addr       (inst_addr),
        .curr_pc_fd      (curr_pc_fd),
        .next_pc_fd      (next_pc_fd),
        .inst            (inst),
        .stall_fetch     (stall_fetch)
    );

    rom #(.XLEN(XLEN), .AWIDTH(AWIDTH)) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (inst_addr),
        .qout  (inst_data)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb_q[$];
    logic [31:0] model_mem [0:(2**AWIDTH)-1];
    logic [31:0] model_pc;
    logic [31:0] held;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] word_idx(input logic [31:0] pc);
        return {20'd0, pc[13:2]};
    endfunction

    function automatic logic [31:0] jump_model(input logic [31:0] t);
`ifdef FETCH_JUMP_ALIGN_EN
        return {t[31:2], 2'b00};
`else
        return t;
`endif
    endfunction

    // One clock cycle: drive just after the rising edge, return at the falling edge for sampling.
    task automatic cyc(input logic pf, input logic pw, input logic j, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        phase_fetch     = pf;
        phase_writeback = pw;
        jump_state_wf   = j;
        regdata_for_pc  = tgt;
        @(negedge clk);
    endtask

    // Fetch, decode, execute, memory, writeback for one instruction.
    task automatic run_instr(input logic jm, input logic jw, input logic [31:0] tgt, input string nm);
        logic [31:0] e;
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check_val({nm, "_stall_f"}, {31'd0, stall_fetch}, 32'd1);
        check_val({nm, "_addr"}, {20'd0, inst_addr}, word_idx(model_pc));
        check_val({nm, "_pc"}, curr_pc_fd, model_pc);
        check_val({nm, "_npc"}, next_pc_fd, model_pc + 32'd4);
        sb_q.push_back(model_mem[word_idx(model_pc)]);

        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check_val({nm, "_stall_d"}, {31'd0, stall_fetch}, 32'd0);
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_sb: got empty queue expected one entry", nm);
            e = 32'hx;
        end else begin
            e = sb_q.pop_front();
        end
        check_val({nm, "_inst_d"}, inst, e);
        held = e;

        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check_val({nm, "_inst_e"}, inst, held);

        cyc(1'b0, 1'b0, jm, tgt);
        check_val({nm, "_inst_m"}, inst, held);
        check_val({nm, "_pc_m"}, curr_pc_fd, model_pc);

        cyc(1'b0, 1'b1, jw, tgt);
        check_val({nm, "_inst_w"}, inst, held);
        check_val({nm, "_pc_w"}, curr_pc_fd, model_pc);
        model_pc = jw ? jump_model(tgt) : model_pc + 32'd4;
    endtask

    initial begin
        rst_n           = 1'b1;
        phase_fetch     = 1'b1;
        phase_writeback = 1'b0;
        jump_state_wf   = 1'b0;
        regdata_for_pc  = '0;
        for (int i = 0; i < 2**AWIDTH; i++) begin
            model_mem[i] = (32'(i) * 32'h0001_0007) ^ 32'h5A00_0033;
        end
        model_mem[0] = 32'h0000_0093;
        for (int i = 0; i < 2**AWIDTH; i++) begin
            u_rom.mem[i] = model_mem[i];
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_pc", curr_pc_fd, RST_PC);
        check_val("rst_npc", next_pc_fd, 32'h8000_0004);
        check_val("rst_inst", inst, NOP_I);
        check_val("rst_stall", {31'd0, stall_fetch}, 32'd0);
        check_val("rst_qout", inst_data, 32'd0);
        check_val("rst_addr", {20'd0, inst_addr}, 32'd0);

        #1;
        rst_n       = 1'b0;
        phase_fetch = 1'b0;
        model_pc    = RST_PC;

        run_instr(1'b0, 1'b0, 32'h0, "seq0");
        run_instr(1'b0, 1'b0, 32'h0, "seq1");
        run_instr(1'b1, 1'b1, 32'h8000_0100, "jmp");
        run_instr(1'b1, 1'b0, 32'h8000_0200, "jmp_at_0x100");
        run_instr(1'b0, 1'b1, 32'h8000_3FFC, "drop_chk");
        run_instr(1'b0, 1'b0, 32'h0, "wrap_a");
        run_instr(1'b0, 1'b1, 32'h8000_0103, "wrap_b");
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_JUMP_ALIGN_EN
        check_val("unal_pc", curr_pc_fd, 32'h8000_0100);
`else
        check_val("unal_pc", curr_pc_fd, 32'h8000_0103);
`endif
        run_instr(1'b0, 1'b0, 32'h0, "unal");

        // Asynchronous reset in the middle of a fetch.
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        rst_n = 1'b1;
        #1;
        check_val("mid_rst_pc", curr_pc_fd, RST_PC);
        check_val("mid_rst_npc", next_pc_fd, 32'h8000_0004);
        check_val("mid_rst_inst", inst, NOP_I);
        check_val("mid_rst_stall", {31'd0, stall_fetch}, 32'd0);
        check_val("mid_rst_qout", inst_data, 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        phase_fetch = 1'b0;
        model_pc    = RST_PC;
        run_instr(1'b0, 1'b0, 32'h0, "post_rst");
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check_val("final_pc", curr_pc_fd, 32'h8000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/top_fetch.md
TOP_FETCH -- requirements
Module: top_fetch (companion: rom)

Interface
REQ-001 SHALL use reset rst_n, asynchronous, active-high; clock clk.
REQ-002 SHALL have parameter XLEN, default 32, meaning data/PC width.
REQ-003 SHALL have parameter AWIDTH, default 12, meaning ROM word-address width.
REQ-004 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning PC after reset.
REQ-005 top_fetch ports, one per line:
- clk  in  1  clock.
- rst_n  in  1  reset.
- phase_fetch  in  1  fetch phase.
- phase_writeback  in  1  writeback phase.
- jump_state_wf  in  1  next PC is a jump.
- regdata_for_pc  in  XLEN  jump target.
- inst_data  in  XLEN  ROM read data.
- inst_addr  out  AWIDTH  ROM word address.
- curr_pc_fd  out  XLEN  current PC.
- next_pc_fd  out  XLEN  sequential PC.
- inst  out  XLEN  fetched instruction.
- stall_fetch  out  1  instruction not yet available.
REQ-006 rom ports, one per line:
- clk  in  1.
- rst_n  in  1.
- addr  in  AWIDTH  word address.
- qout  out  XLEN  registered read data.
- The array is named mem, depth 2^AWIDTH, and is loadable by hex file.

Function
REQ-007 PC register drives curr_pc_fd; next_pc_fd = PC+4, modulo 2^XLEN.
REQ-008 inst_addr = PC[AWIDTH+1:2], combinational; upper PC bits ignored, so the address wraps within the ROM.
REQ-009 PC updates only on a posedge with phase_writeback=1: jump_state_wf=1 -> regdata_for_pc, else PC+4; otherwise PC holds.
REQ-010 jump_state_wf and regdata_for_pc are ignored outside phase_writeback.
REQ-011 rom: qout <= mem[addr] every posedge; one-cycle read latency; no write port.
REQ-012 The address presented during the phase_fetch cycle returns data in the following (decode) cycle.
REQ-013 stall_fetch = 1 during any cycle with phase_fetch=1, else 0.
REQ-014 During the cycle after phase_fetch, inst = inst_data (pass-through); a hold register captures inst_data at the end of that cycle.
REQ-015 inst = hold register in all other cycles, stable until the next fetch.
REQ-016 If phase_fetch and phase_writeback are both 1, the writeback PC update takes effect first; the fetch uses the new PC from the next cycle.

Reset
REQ-017 While rst_n is asserted, outputs SHALL be:
- PC = RESET_PC, so curr_pc_fd = 32'h8000_0000 and next_pc_fd = 32'h8000_0004.
- inst hold register = 32'h0000_0013 (NOP).
- stall_fetch = 0.
- rom qout = 0.
REQ-018 Reset asserted mid-operation returns all state to the REQ-017 values immediately; mem contents are preserved.

Configuration
REQ-019 Macro FETCH_JUMP_ALIGN_EN:
- Defined: jump target bits [1:0] are forced to 0 before loading the PC.
- Undefined: regdata_for_pc loads verbatim.

Structure
REQ-020 Shared package core_general SHALL hold XLEN, AWIDTH, RESET_PC and the NOP constant (32'h0000_0013).
REQ-021 rom SHALL be a separate sub-module instantiated beside top_fetch; top_fetch has no further sub-modules.

Verification
REQ-022 Reset release, no jump -> curr_pc_fd = 8000_0000 and inst_addr = 0x000; after the first writeback, curr_pc_fd = 8000_0004 and inst_addr = 0x001.
REQ-023 mem[0] = 0x00000093, fetch at PC 8000_0000 -> inst = 0x00000093 in the decode cycle, held through writeback; stall_fetch = 1 only in the fetch cycle.
REQ-024 jump_state_wf = 1 and regdata_for_pc = 8000_0100 across memory and writeback -> next curr_pc_fd = 8000_0100 and inst_addr = 0x040.
REQ-025 jump_state_wf = 1 only during phase_memory, dropped before writeback -> PC = PC+4 (no jump).
REQ-026 PC = 8000_3FFC, sequential advance -> inst_addr goes 0xFFF then 0x000 (wrap); next_pc_fd = 8000_4000.
REQ-027 With FETCH_JUMP_ALIGN_EN defined, jump to 8000_0103 -> curr_pc_fd = 8000_0100; undefined -> 8000_0103.
